// File: rtl/dafx_pkg.sv
// DAFX shared definitions.
// Default widths and counts for the ADC router and IRQ timers.
package dafx_pkg;

    localparam int AUDIO_WIDTH_C          = 24;
    localparam int NR_OF_ADC_CH_C         = 2;
    localparam int NR_OF_IRQ_C            = 2;
    localparam int SAMPLING_IRQ_COUNTER_C = 32;
    localparam int ERR_CNT_WIDTH_C        = 16;

    typedef logic [AUDIO_WIDTH_C-1:0] audio_sample_t;

endpackage

// File: rtl/dafx_adc_router_if.sv
// DAFX ADC sample stream.
// One beat per channel; last marks the frame end.
interface dafx_adc_router_if
    import dafx_pkg::*;
#(
    parameter int AUDIO_WIDTH_P = AUDIO_WIDTH_C
) ();

    logic [AUDIO_WIDTH_P-1:0] adc_data;
    logic                     adc_valid;
    logic                     adc_ready;
    logic                     adc_last;

    modport master (
        output adc_data,
        output adc_valid,
        output adc_last,
        input  adc_ready
    );

    modport slave (
        input  adc_data,
        input  adc_valid,
        input  adc_last,
        output adc_ready
    );

endinterface

// File: rtl/dafx_irq_timer.sv
// DAFX programmable period timer.
// Pulse or sticky interrupt; period 0 disables counting.
module dafx_irq_timer
    import dafx_pkg::*;
#(
    parameter int CNT_WIDTH_P = SAMPLING_IRQ_COUNTER_C
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [CNT_WIDTH_P-1:0] period,
    input  logic                   sticky,
    input  logic                   clear,
    output logic                   irq
);

    logic [CNT_WIDTH_P-1:0] cnt;
    logic                   tick;

    // >= so a period shortened mid-count fires at once instead of wrapping
    assign tick = (period != '0) && (cnt >= period - CNT_WIDTH_P'(1));

    // period counter, held at 0 while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (period == '0 || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_WIDTH_P'(1);
        end
    end

    // irq output: set beats clear in sticky mode, pulse mode drops any level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else if (sticky) begin
            irq <= tick | (irq & ~clear);
        end else begin
            irq <= tick;
        end
    end

endmodule

// File: rtl/dafx_adc_router.sv
// DAFX ADC front end: frame deserialiser, frame stats, IRQ timers.
// Channel registers update only on a frame of exactly N beats.
module dafx_adc_router
    import dafx_pkg::*;
#(
    parameter int AUDIO_WIDTH_P   = AUDIO_WIDTH_C,
    parameter int NR_OF_ADC_CH_P  = NR_OF_ADC_CH_C,
    parameter int NR_OF_IRQ_P     = NR_OF_IRQ_C,
    parameter int IRQ_CNT_WIDTH_P = SAMPLING_IRQ_COUNTER_C,
    parameter int ERR_CNT_WIDTH_P = ERR_CNT_WIDTH_C
) (
    input  logic                       clk,
    input  logic                       rst_n,
    dafx_adc_router_if.slave           adc,
    output logic [0:NR_OF_ADC_CH_P-1][AUDIO_WIDTH_P-1:0] ch_data,
    output logic                       fs_strobe,
    input  logic [0:NR_OF_IRQ_P-1][IRQ_CNT_WIDTH_P-1:0] cr_irq_period,
    input  logic [NR_OF_IRQ_P-1:0]     cr_irq_sticky,
    input  logic [NR_OF_IRQ_P-1:0]     cmd_irq_clear,
    output logic [NR_OF_IRQ_P-1:0]     irq,
    input  logic                       cmd_clear_stats,
    output logic [31:0]                sr_frame_count,
    output logic [ERR_CNT_WIDTH_P-1:0] sr_frame_err
);

    localparam int IDX_W = $clog2(NR_OF_ADC_CH_P + 1);
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(NR_OF_ADC_CH_P);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NR_OF_ADC_CH_P - 1);

    logic                     ready_q;
    logic [IDX_W-1:0]         idx;
    logic [AUDIO_WIDTH_P-1:0] shadow [NR_OF_ADC_CH_P];
    logic                     accept;
    logic                     good_frame;
    logic                     bad_frame;

    assign adc.adc_ready = ready_q;
    assign accept        = adc.adc_valid & ready_q;
    assign good_frame    = accept & adc.adc_last & (idx == IDX_LAST);
    assign bad_frame     = accept & adc.adc_last & (idx != IDX_LAST);

    // ready comes up one edge after reset and never drops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    // beat capture, frame commit and strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            fs_strobe <= 1'b0;
            ch_data   <= '0;
            for (int i = 0; i < NR_OF_ADC_CH_P; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            fs_strobe <= good_frame;
            if (accept) begin
                for (int i = 0; i < NR_OF_ADC_CH_P; i++) begin
                    if (idx == IDX_W'(i)) begin
                        shadow[i] <= adc.adc_data;
                    end
                end
                if (adc.adc_last) begin
                    idx <= '0;
                end else if (idx != IDX_MAX) begin
                    idx <= idx + IDX_W'(1);
                end
            end
            if (good_frame) begin
                for (int i = 0; i < NR_OF_ADC_CH_P - 1; i++) begin
                    ch_data[i] <= shadow[i];
                end
                ch_data[NR_OF_ADC_CH_P-1] <= adc.adc_data;
            end
        end
    end

    // frame statistics; clear has priority over counting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_frame_count <= '0;
            sr_frame_err   <= '0;
        end else if (cmd_clear_stats) begin
            sr_frame_count <= '0;
            sr_frame_err   <= '0;
        end else begin
            if (good_frame) begin
                sr_frame_count <= sr_frame_count + 32'd1;
            end
            if (bad_frame && sr_frame_err != '1) begin
                sr_frame_err <= sr_frame_err + ERR_CNT_WIDTH_P'(1);
            end
        end
    end

    for (genvar g = 0; g < NR_OF_IRQ_P; g++) begin : g_irq
        dafx_irq_timer #(
            .CNT_WIDTH_P (IRQ_CNT_WIDTH_P)
        ) u_timer (
            .clk    (clk),
            .rst_n  (rst_n),
            .period (cr_irq_period[g]),
            .sticky (cr_irq_sticky[g]),
            .clear  (cmd_irq_clear[g]),
            .irq    (irq[g])
        );
    end

endmodule
